// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: shares the register-file write port between NUM_REQ
// writeback requesters. A round-robin pick feeds a one-entry output register,
// so the wr_* interface is driven straight from flops. Requests that target
// register 0 are accepted and dropped.
module rf_writeback_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int RF_WIDTH   = 5,
  localparam int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           halt,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*RF_WIDTH-1:0]    req_rd,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [RF_WIDTH-1:0]            wr_rd,
  output logic [TAG_WIDTH-1:0]           wr_tag,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic [SEL_W-1:0]               wr_src
);

  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [RF_WIDTH-1:0]   wr_rd_q, wr_rd_d;
  logic [TAG_WIDTH-1:0]  wr_tag_q, wr_tag_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SEL_W-1:0]      wr_src_q, wr_src_d;

  logic [SEL_W-1:0]      scan_idx;
  logic [SEL_W-1:0]      win_idx;
  logic                  win_found;
  logic                  slot_free;
  logic                  accept;
  logic                  draining;
  logic [RF_WIDTH-1:0]   win_rd;
  logic [TAG_WIDTH-1:0]  win_tag;
  logic [DATA_WIDTH-1:0] win_data;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping
  // naturally because NUM_REQ is a power of two.
  always_comb begin
    scan_idx  = rr_ptr_q;
    win_idx   = rr_ptr_q;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + SEL_W'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // The output register can take a new entry when empty or leaving this cycle;
  // halt, flush and reset all block acceptance.
  always_comb begin
    slot_free = ~wr_valid_q | wr_ready;
    draining  = wr_valid_q & wr_ready;
    accept    = win_found & slot_free & ~halt & ~flush & ~rst;
    win_rd    = req_rd[win_idx*RF_WIDTH +: RF_WIDTH];
    win_tag   = req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH];
    win_data  = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // One-hot ready, only ever on the winning (hence valid) requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept & (win_idx == SEL_W'(gi));
    end
  endgenerate

  // Next state of the output stage and round-robin pointer; flush wins over
  // everything and leaves the pointer alone.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_valid_d = wr_valid_q;
    wr_rd_d    = wr_rd_q;
    wr_tag_d   = wr_tag_q;
    wr_data_d  = wr_data_q;
    wr_src_d   = wr_src_q;
    if (flush) begin
      wr_valid_d = 1'b0;
    end else if (accept) begin
      rr_ptr_d = win_idx + SEL_W'(1);
      if (|win_rd) begin
        wr_valid_d = 1'b1;
        wr_rd_d    = win_rd;
        wr_tag_d   = win_tag;
        wr_data_d  = win_data;
        wr_src_d   = win_idx;
      end else if (draining) begin
        wr_valid_d = 1'b0;
      end
    end else if (draining) begin
      wr_valid_d = 1'b0;
    end
  end

  // State register; reset clears the pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_rd_q    <= '0;
      wr_tag_q   <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_rd_q    <= wr_rd_d;
      wr_tag_q   <= wr_tag_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_rd    = wr_rd_q;
  assign wr_tag   = wr_tag_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: the stimulus pushes each expected RF
// write into a queue, a monitor pops and compares on every wr handshake.
module tb_rf_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            halt = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_rd = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            wr_valid;
  logic            wr_ready = 1'b1;
  logic [RW-1:0]   wr_rd;
  logic [TW-1:0]   wr_tag;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_src;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [RW-1:0] rd;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;
  exp_t exp_q[$];

  logic [RW-1:0] rd_tab   [N] = '{5'd5, 5'd6, 5'd9, 5'd7};
  logic [TW-1:0] tag_tab  [N] = '{7'h12, 7'h21, 7'h44, 7'h33};
  logic [DW-1:0] data_tab [N] = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};

  rf_writeback_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .RF_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_tag(req_tag), .req_data(req_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rd(wr_rd), .wr_tag(wr_tag), .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic load_tables();
    for (int i = 0; i < N; i++) begin
      req_rd[i*RW +: RW]   = rd_tab[i];
      req_tag[i*TW +: TW]  = tag_tab[i];
      req_data[i*DW +: DW] = data_tab[i];
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.rd = rd_tab[i]; e.tag = tag_tab[i]; e.data = data_tab[i]; e.src = 2'(i);
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one RF write completes per cycle where wr_valid & wr_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got src=%0d rd=%0d, expected no write", wr_src, wr_rd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          vectors++;
          if (wr_rd !== e.rd || wr_tag !== e.tag || wr_data !== e.data || wr_src !== e.src) begin
            miscompares++;
            $display("FAIL wr_txn: got src=%0d rd=%0d tag=0x%0h data=0x%0h, expected src=%0d rd=%0d tag=0x%0h data=0x%0h",
                     wr_src, wr_rd, wr_tag, wr_data, e.src, e.rd, e.tag, e.data);
          end else begin
            $display("ok   wr_txn src=%0d rd=%0d tag=0x%0h data=0x%0h", wr_src, wr_rd, wr_tag, wr_data);
          end
        end
      end
    end
  end

  initial begin
    load_tables();
    // Reset state, with requests presented to prove ready stays low.
    req_valid = 4'b1111;
    step(); step();
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wr_valid", 64'(wr_valid), 64'h0);
    check("rst_wr_fields", {wr_rd, wr_tag, wr_src}, 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    step();
    rst = 1'b0;
    req_valid = '0;

    // Single request from requester 0.
    step(); req_valid = 4'b0001; #1;
    check("t1_ready", 64'(req_ready), 64'b0001); push_exp(0);
    // Pointer now 1: requester 1 beats 0.
    step(); req_valid = 4'b0011; #1;
    check("t1_wr_valid", 64'(wr_valid), 64'h1);
    check("t1_ptr1_ready", 64'(req_ready), 64'b0010); push_exp(1);
    // Pointer now 2: requester 3 beats 0.
    step(); req_valid = 4'b1001; #1;
    check("t1_ptr2_ready", 64'(req_ready), 64'b1000); push_exp(3);

    // All valid: grants 0,1,2,3,0 back to back.
    for (int k = 0; k < 5; k++) begin
      step(); req_valid = 4'b1111; #1;
      check($sformatf("t2_ready_%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      push_exp(k % 4);
    end

    // Backpressure for three cycles: entry from requester 0 held.
    for (int k = 0; k < 3; k++) begin
      step(); wr_ready = 1'b0; #1;
      check($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'h0);
      check($sformatf("t3_hold_%0d", k), {wr_valid, wr_src, wr_rd, wr_data}, {1'b1, 2'd0, 5'd5, 32'hDEADBEEF});
    end
    step(); wr_ready = 1'b1; #1;
    check("t3_release_ready", 64'(req_ready), 64'b0010); push_exp(1);
    step(); req_valid = '0; #1;
    check("t3_next_src", {wr_valid, wr_src}, {1'b1, 2'd1});

    // Write to r0 from requester 2: consumed, nothing written.
    step(); req_rd[2*RW +: RW] = '0; req_valid = 4'b0100; #1;
    check("t4_idle", 64'(wr_valid), 64'h0);
    check("t4_ready", 64'(req_ready), 64'b0100);
    step(); req_valid = '0; #1;
    check("t4_no_write", 64'(wr_valid), 64'h0);
    req_rd[2*RW +: RW] = rd_tab[2];
    // Pointer now 3: requester 0 beats 2.
    step(); req_valid = 4'b0101; #1;
    check("t4_ptr3_ready", 64'(req_ready), 64'b0001); push_exp(0);

    // Halt: entry drains, no accepts, pointer frozen at 1.
    step(); halt = 1'b1; req_valid = 4'b1111; #1;
    check("t5_halt_valid", 64'(wr_valid), 64'h1);
    check("t5_halt_ready0", 64'(req_ready), 64'h0);
    step(); #1;
    check("t5_halt_drained", 64'(wr_valid), 64'h0);
    check("t5_halt_ready1", 64'(req_ready), 64'h0);
    step(); halt = 1'b0; #1;
    check("t5_unhalt_ready", 64'(req_ready), 64'b0010);
    // Hold the new entry, then flush it away.
    step(); wr_ready = 1'b0; flush = 1'b1; #1;
    check("t5_held_entry", {wr_valid, wr_src, wr_rd}, {1'b1, 2'd1, 5'd6});
    check("t5_flush_ready", 64'(req_ready), 64'h0);
    step(); flush = 1'b0; wr_ready = 1'b1; #1;
    check("t5_flushed", 64'(wr_valid), 64'h0);
    check("t5_ptr_kept", 64'(req_ready), 64'b0100); push_exp(2);

    // Async reset mid-cycle with a held entry from requester 3.
    step(); req_valid = 4'b1000; #1;
    check("t6_ready", 64'(req_ready), 64'b1000);
    step(); req_valid = 4'b1111; wr_ready = 1'b0; #1;
    check("t6_held", {wr_valid, wr_src, wr_rd}, {1'b1, 2'd3, 5'd7});
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(wr_valid), 64'h0);
    check("t6_rst_fields", {wr_rd, wr_tag, wr_src}, 64'h0);
    check("t6_rst_data", 64'(wr_data), 64'h0);
    check("t6_rst_ready", 64'(req_ready), 64'h0);
    step(); rst = 1'b0; wr_ready = 1'b1; #1;
    check("t6_restart_ready", 64'(req_ready), 64'b0001); push_exp(0);
    step(); req_valid = '0;
    step(); step();
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
